// File: rtl/cordic_tone_scheduler_if.sv
// cordic_tone_scheduler_if
// Bundles every non-clock/reset signal of the tone scheduler:
//   config bus    : cfg_we, cfg_ch, cfg_step, cfg_en
//   round control : sample_tick, busy, overrun, round_done
//   CORDIC side   : cordic_issue, cordic_angle, cordic_sine, cordic_cosine
//   mixer side    : result_valid, result_ch, result_sine, result_cosine
// Modport slave is the scheduler; master is the surrounding system.
interface cordic_tone_scheduler_if #(
    parameter int NCH   = 4,
    parameter int STEPW = 16,
    parameter int ANGW  = 10,
    parameter int DATAW = 32
);
    localparam int CHW = $clog2(NCH);

    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [STEPW-1:0] cfg_step;
    logic [NCH-1:0]   cfg_en;
    logic             sample_tick;
    logic             busy;
    logic             overrun;
    logic             cordic_issue;
    logic [ANGW-1:0]  cordic_angle;
    logic [DATAW-1:0] cordic_sine;
    logic [DATAW-1:0] cordic_cosine;
    logic             result_valid;
    logic [CHW-1:0]   result_ch;
    logic [DATAW-1:0] result_sine;
    logic [DATAW-1:0] result_cosine;
    logic             round_done;

    modport slave (
        input  cfg_we, cfg_ch, cfg_step, cfg_en, sample_tick, cordic_sine, cordic_cosine,
        output busy, overrun, cordic_issue, cordic_angle,
               result_valid, result_ch, result_sine, result_cosine, round_done
    );

    modport master (
        output cfg_we, cfg_ch, cfg_step, cfg_en, sample_tick, cordic_sine, cordic_cosine,
        input  busy, overrun, cordic_issue, cordic_angle,
               result_valid, result_ch, result_sine, result_cosine, round_done
    );
endinterface

// File: rtl/cordic_tone_scheduler.sv
// cordic_tone_scheduler
// Shares one pipelined CORDIC (fixed latency LAT) among NCH tone channels.
// Each sample_tick starts a round: one slot per channel, in channel order,
// issuing the top ANGW bits of that channel's phase and advancing the phase
// by the channel's step. Issues are tagged with their channel and the tags
// are delayed LAT cycles so returning results can be labelled.
// Ports: clk, reset (async, active high), bus (cordic_tone_scheduler_if.slave).
module cordic_tone_scheduler #(
    parameter int NCH    = 4,
    parameter int STEPW  = 16,
    parameter int PHASEW = 26,
    parameter int ANGW   = 10,
    parameter int DATAW  = 32,
    parameter int LAT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    cordic_tone_scheduler_if.slave  bus
);
    localparam int CHW = $clog2(NCH);
    localparam int DW  = $clog2(LAT + 1);
    localparam logic [CHW-1:0] LAST_SLOT  = CHW'(NCH - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CHW-1:0]    slot_r;
    logic [DW-1:0]     drain_r;
    logic [PHASEW-1:0] phase_r       [NCH];
    logic [STEPW-1:0]  step_r        [NCH];
    logic [STEPW-1:0]  shadow_step_r [NCH];
    logic [NCH-1:0]    shadow_en_r;
    logic [CHW:0]      tag_r         [LAT];   // {issued, channel}

    logic              issue_r, busy_r, overrun_r, done_r;
    logic [ANGW-1:0]   angle_r;
    logic              rvalid_r;
    logic [CHW-1:0]    rch_r;
    logic [DATAW-1:0]  rsine_r, rcos_r;

    logic              slot_go_s;
    logic [CHW-1:0]    sel_s;
    logic              sel_en_s;
    logic [STEPW-1:0]  sel_step_s;

    // Selects the slot whose issue registers load at this edge. Slot 0 is
    // launched straight from the tick, so it reads the live enables/steps,
    // which are exactly what the snapshot captures at the same edge.
    always_comb begin
        slot_go_s  = 1'b0;
        sel_s      = '0;
        sel_en_s   = 1'b0;
        sel_step_s = '0;
        if (state_r == IDLE && bus.sample_tick) begin
            slot_go_s  = 1'b1;
            sel_en_s   = bus.cfg_en[0];
            sel_step_s = step_r[0];
        end else if (state_r == ISSUE && slot_r != LAST_SLOT) begin
            slot_go_s  = 1'b1;
            sel_s      = slot_r + CHW'(1);
            sel_en_s   = shadow_en_r[sel_s];
            sel_step_s = shadow_step_r[sel_s];
        end else begin
            slot_go_s  = 1'b0;
        end
    end

    // Round sequencing: ISSUE spans NCH slots, DRAIN lasts LAT+1 cycles so the
    // last tag has produced its result before DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = bus.sample_tick ? ISSUE : IDLE;
            ISSUE:   state_s = (slot_r == LAST_SLOT) ? DRAIN : ISSUE;
            DRAIN:   state_s = (drain_r == DRAIN_LAST) ? DONE : DRAIN;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control state, status flags, snapshot and registered CORDIC issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            slot_r      <= '0;
            drain_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
            issue_r     <= 1'b0;
            angle_r     <= '0;
            shadow_en_r <= '0;
            for (int i = 0; i < NCH; i++) shadow_step_r[i] <= '0;
        end else begin
            state_r <= state_s;
            drain_r <= (state_r == DRAIN) ? drain_r + DW'(1) : '0;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            if (bus.sample_tick && busy_r) overrun_r <= 1'b1;
            if (slot_go_s) slot_r <= sel_s;
            if (state_r == IDLE && bus.sample_tick) begin
                shadow_en_r <= bus.cfg_en;
                for (int i = 0; i < NCH; i++) shadow_step_r[i] <= step_r[i];
            end
            issue_r <= slot_go_s & sel_en_s;
            angle_r <= (slot_go_s & sel_en_s) ? phase_r[sel_s][PHASEW-1 -: ANGW] : '0;
        end
    end

    // Step working copy (writable any time) and phase accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                step_r[i]  <= '0;
                phase_r[i] <= '0;
            end
        end else begin
            if (bus.cfg_we) step_r[bus.cfg_ch] <= bus.cfg_step;
            if (slot_go_s && sel_en_s)
                phase_r[sel_s] <= phase_r[sel_s] + PHASEW'(sel_step_s);
        end
    end

    // Tag delay line: tag_r[LAT-1] lines up with the CORDIC result cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) tag_r[i] <= '0;
        end else begin
            tag_r[0] <= {issue_r, slot_r};
            for (int i = 1; i < LAT; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    // Result capture; data holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_r <= 1'b0;
            rch_r    <= '0;
            rsine_r  <= '0;
            rcos_r   <= '0;
        end else begin
            rvalid_r <= tag_r[LAT-1][CHW];
            if (tag_r[LAT-1][CHW]) begin
                rch_r   <= tag_r[LAT-1][CHW-1:0];
                rsine_r <= bus.cordic_sine;
                rcos_r  <= bus.cordic_cosine;
            end
        end
    end

    assign bus.busy          = busy_r;
    assign bus.overrun       = overrun_r;
    assign bus.round_done    = done_r;
    assign bus.cordic_issue  = issue_r;
    assign bus.cordic_angle  = angle_r;
    assign bus.result_valid  = rvalid_r;
    assign bus.result_ch     = rch_r;
    assign bus.result_sine   = rsine_r;
    assign bus.result_cosine = rcos_r;
endmodule

// File: tb/tb_cordic_tone_scheduler.sv
// Bench for cordic_tone_scheduler: table of rounds with expected angles,
// a cycle-accurate scoreboard of issues/results/round_done, a fake fixed-
// latency CORDIC whose outputs encode issue cycle and angle, and hand-made
// sequences for mid-round config, overrun, mid-round reset and phase wrap.
module tb_cordic_tone_scheduler;
    localparam int NCH = 4, STEPW = 20, PHASEW = 26, ANGW = 10, DATAW = 32, LAT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cordic_tone_scheduler_if #(.NCH(NCH), .STEPW(STEPW), .ANGW(ANGW), .DATAW(DATAW)) bus();

    cordic_tone_scheduler #(.NCH(NCH), .STEPW(STEPW), .PHASEW(PHASEW), .ANGW(ANGW),
                            .DATAW(DATAW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { longint c; logic [1:0] ch; logic [9:0] ang; } exp_t;
    typedef struct { logic [3:0] en; logic [3:0][9:0] ang; } row_t;

    int        checks = 0;
    int        errors = 0;
    longint    cyc = 0;
    longint    bfrom = 1, bto = 0, round_t = 0;
    exp_t      iss_q[$], res_q[$];
    longint    done_q[$];
    logic [25:0] mph   [4];
    logic [19:0] mstep [4];
    logic [31:0] last_sine;
    logic [10:0] hist  [64];
    row_t      tbl [5];

    function automatic logic [31:0] f_sine(longint c, logic [9:0] a);
        logic [63:0] cc;
        cc = c;
        return {cc[21:0], a};
    endfunction

    function automatic logic [31:0] f_cos(longint c, logic [9:0] a);
        return ~f_sine(c, a) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input longint target);
        while (cyc < target) step();
    endtask

    task automatic cfg_write(input int ch, input logic [19:0] s);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_step = s;
        mstep[ch]    = s;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_round(input logic [3:0] en, input logic [3:0][9:0] ang);
        longint t;
        t = cyc;
        bus.cfg_en      = en;
        bus.sample_tick = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (en[k]) begin
                iss_q.push_back('{t + 1 + k, 2'(k), ang[k]});
                res_q.push_back('{t + LAT + 2 + k, 2'(k), ang[k]});
                last_sine = f_sine(t + 1 + k, ang[k]);
                mph[k] = mph[k] + 26'(mstep[k]);
            end
        end
        done_q.push_back(t + NCH + LAT + 2);
        bfrom   = t + 1;
        bto     = t + NCH + LAT + 2;
        round_t = t;
        step();
        bus.sample_tick = 1'b0;
    endtask

    task automatic start_model(input logic [3:0] en);
        logic [3:0][9:0] a;
        for (int k = 0; k < NCH; k++) a[k] = mph[k][25:16];
        start_round(en, a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        iss_q.delete(); res_q.delete(); done_q.delete();
        for (int k = 0; k < NCH; k++) begin mph[k] = '0; mstep[k] = '0; end
        bfrom = 1; bto = 0; last_sine = '0;
        check("rst_busy",    bus.busy,          1'b0);
        check("rst_overrun", bus.overrun,       1'b0);
        check("rst_issue",   bus.cordic_issue,  1'b0);
        check("rst_angle",   bus.cordic_angle,  10'd0);
        check("rst_rvalid",  bus.result_valid,  1'b0);
        check("rst_rch",     bus.result_ch,     2'd0);
        check("rst_rsine",   bus.result_sine,   32'd0);
        check("rst_rcos",    bus.result_cosine, 32'd0);
        check("rst_done",    bus.round_done,    1'b0);
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard checks and fake CORDIC, both at the falling edge.
    initial begin
        logic e;
        logic [10:0] h;
        forever begin
            @(negedge clk);
            if (!reset) begin
                e = 1'b0;
                if (iss_q.size() > 0) e = (iss_q[0].c == cyc);
                if (e || bus.cordic_issue === 1'b1) begin
                    check("cordic_issue", bus.cordic_issue, e);
                    if (e) begin
                        check("cordic_angle", bus.cordic_angle, iss_q[0].ang);
                        void'(iss_q.pop_front());
                    end
                end
                e = 1'b0;
                if (res_q.size() > 0) e = (res_q[0].c == cyc);
                if (e || bus.result_valid === 1'b1) begin
                    check("result_valid", bus.result_valid, e);
                    if (e) begin
                        check("result_ch",  bus.result_ch, res_q[0].ch);
                        check("result_sine", bus.result_sine, f_sine(res_q[0].c - LAT - 1, res_q[0].ang));
                        check("result_cos",  bus.result_cosine, f_cos(res_q[0].c - LAT - 1, res_q[0].ang));
                        void'(res_q.pop_front());
                    end
                end
                e = 1'b0;
                if (done_q.size() > 0) e = (done_q[0] == cyc);
                if (e || bus.round_done === 1'b1) begin
                    check("round_done", bus.round_done, e);
                    if (e) void'(done_q.pop_front());
                end
                check("busy", bus.busy, (cyc >= bfrom && cyc <= bto));
            end
            hist[int'(cyc % 64)] = {bus.cordic_issue, bus.cordic_angle};
            if (cyc >= LAT) begin
                h = hist[int'((cyc - LAT) % 64)];
                bus.cordic_sine   = h[10] ? f_sine(cyc - LAT, h[9:0]) : 32'hDEAD_BEEF;
                bus.cordic_cosine = h[10] ? f_cos(cyc - LAT, h[9:0])  : 32'hBEEF_DEAD;
            end
        end
    end

    initial begin
        longint t;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_step = '0; bus.cfg_en = '0;
        bus.sample_tick = 1'b0; bus.cordic_sine = '0; bus.cordic_cosine = '0;
        tbl[0] = '{4'hF, {10'd0, 10'd0, 10'd0, 10'd0}};
        tbl[1] = '{4'hF, {10'd3, 10'd0, 10'd2, 10'd1}};
        tbl[2] = '{4'hF, {10'd6, 10'd0, 10'd4, 10'd2}};
        tbl[3] = '{4'h5, {10'd0, 10'd0, 10'd0, 10'd3}};
        tbl[4] = '{4'hF, {10'd9, 10'd0, 10'd6, 10'd4}};

        do_reset();
        cfg_write(0, 20'h10000);
        cfg_write(1, 20'h20000);
        cfg_write(2, 20'h00000);
        cfg_write(3, 20'h30000);

        for (int i = 0; i < 5; i++) begin
            start_round(tbl[i].en, tbl[i].ang);
            repeat (38) step();
            check("hold_sine", bus.result_sine, last_sine);
            check("idle_rvalid", bus.result_valid, 1'b0);
        end

        // step write at t+2 only affects the following round
        start_model(4'hF);
        step();
        cfg_write(0, 20'h50000);
        repeat (36) step();
        start_model(4'hF);
        repeat (38) step();
        start_model(4'hF);
        repeat (38) step();

        // ticks while busy are ignored and latch overrun
        check("overrun_clear", bus.overrun, 1'b0);
        start_model(4'hF);
        t = round_t;
        goto(t + 5);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        check("overrun_set", bus.overrun, 1'b1);
        goto(t + 22);
        bus.sample_tick = 1'b1;
        step();
        start_model(4'hF);
        repeat (38) step();
        check("overrun_sticky", bus.overrun, 1'b1);

        // reset in the middle of a round
        start_model(4'hF);
        t = round_t;
        goto(t + 10);
        do_reset();
        repeat (30) step();
        start_round(4'hF, {10'd0, 10'd0, 10'd0, 10'd0});
        repeat (38) step();

        // phase wrap: 64 rounds of 0xFFC00 reach 0x3FF0000
        cfg_write(0, 20'hFFC00);
        for (int r = 0; r < 64; r++) begin
            start_model(4'b0001);
            repeat (23) step();
        end
        cfg_write(0, 20'h20000);
        start_round(4'b0001, {10'd0, 10'd0, 10'd0, 10'h3FF});
        repeat (23) step();
        start_round(4'b0001, {10'd0, 10'd0, 10'd0, 10'h001});
        repeat (30) step();

        check("iss_q_empty",  iss_q.size(),  0);
        check("res_q_empty",  res_q.size(),  0);
        check("done_q_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
